// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: hex / unsigned-decimal view of a result
// value with a retriggerable timed message overlay. Decimal conversion is a
// sequential double-dabble whose result is latched only on completion.
module seg_display_ctrl #(
    parameter int DIGITS     = 6,
    parameter int VAL_W      = 24,
    parameter int TIMEOUT_MS = 3000,
    parameter int LZB        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  oneMsPulse,
    input  logic                  dispMode,
    input  logic [VAL_W-1:0]      Value,
    input  logic                  ShowMsg,
    input  logic [5*DIGITS-1:0]   MsgChars,
    output logic                  Busy,
    output logic                  OverlayActive,
    output logic [8*DIGITS-1:0]   HEX
);

    // Enough BCD digits to hold the largest VAL_W-bit value.
    localparam int NBCD  = (VAL_W * 3) / 10 + 1;
    // Only the digits that can actually be displayed are latched.
    localparam int NSHOW = (NBCD < DIGITS) ? NBCD : DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    localparam logic [4:0] CH_E     = 5'h0E;
    localparam logic [4:0] CH_R     = 5'h10;
    localparam logic [4:0] CH_BLANK = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------
    // Decimal converter state
    // ------------------------------------------------------------------
    conv_state_t            state_reg, state_next;
    logic [VAL_W-1:0]       shift_reg, shift_next;
    logic [VAL_W-1:0]       last_conv_reg, last_conv_next;
    logic [4*NBCD-1:0]      bcd_reg, bcd_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [4*NSHOW-1:0]     dec_digits_reg, dec_digits_next;
    logic                   overflow_reg, overflow_next;

    logic [4*NBCD-1:0]      bcd_adj;
    logic [4*NBCD-1:0]      bcd_shifted;
    logic                   ovf_calc;

    // ------------------------------------------------------------------
    // Overlay and display state
    // ------------------------------------------------------------------
    logic [5*DIGITS-1:0]    msg_reg;
    logic                   overlay_reg;
    logic [15:0]            ms_cnt_reg;
    logic [5*DIGITS-1:0]    char_reg, char_next;
    logic                   hex_err;
    logic [DIGITS-1:0]      dec_nz;
    logic                   unused_bits;

    // Add-3 correction applied to every BCD digit before each shift.
    generate
        for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        (bcd_reg[4*gi +: 4] + 4'd3) :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    // The top adjusted bit can never be set for a correctly sized NBCD.
    assign bcd_shifted = {bcd_adj[4*NBCD-2:0], shift_reg[VAL_W-1]};

    // Decimal overflow: any BCD digit beyond the physical displays.
    generate
        if (NBCD > DIGITS) begin : g_ovf
            assign ovf_calc = |bcd_reg[4*NBCD-1:4*DIGITS];
        end else begin : g_no_ovf
            assign ovf_calc = 1'b0;
        end
    endgenerate

    // Hex overflow: value bits above the displayable nibbles.
    generate
        if (VAL_W > 4*DIGITS) begin : g_hex_err
            assign hex_err = |Value[VAL_W-1:4*DIGITS];
        end else begin : g_no_hex_err
            assign hex_err = 1'b0;
        end
    endgenerate

    assign Busy          = (state_reg != ST_IDLE);
    assign OverlayActive = overlay_reg;

    // Converter next-state and datapath; a Value change restarts the shift.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        last_conv_next  = last_conv_reg;
        bcd_next        = bcd_reg;
        cnt_next        = cnt_reg;
        dec_digits_next = dec_digits_reg;
        overflow_next   = overflow_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Value != last_conv_reg) begin
                    shift_next     = Value;
                    last_conv_next = Value;
                    bcd_next       = '0;
                    cnt_next       = CNT_W'(VAL_W);
                    state_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (Value != last_conv_reg) begin
                    shift_next     = Value;
                    last_conv_next = Value;
                    bcd_next       = '0;
                    cnt_next       = CNT_W'(VAL_W);
                end else begin
                    bcd_next   = bcd_shifted;
                    shift_next = {shift_reg[VAL_W-2:0], 1'b0};
                    cnt_next   = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                dec_digits_next = bcd_reg[4*NSHOW-1:0];
                overflow_next   = ovf_calc;
                state_next      = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Converter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            last_conv_reg  <= '0;
            bcd_reg        <= '0;
            cnt_reg        <= '0;
            dec_digits_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            last_conv_reg  <= last_conv_next;
            bcd_reg        <= bcd_next;
            cnt_reg        <= cnt_next;
            dec_digits_reg <= dec_digits_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Overlay timer: ShowMsg (re)captures and restarts, and wins over timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_reg     <= {DIGITS{CH_BLANK}};
            overlay_reg <= 1'b0;
            ms_cnt_reg  <= '0;
        end else if (ShowMsg) begin
            msg_reg     <= MsgChars;
            overlay_reg <= 1'b1;
            ms_cnt_reg  <= '0;
        end else if (overlay_reg && oneMsPulse) begin
            if (ms_cnt_reg == 16'(TIMEOUT_MS - 1)) begin
                overlay_reg <= 1'b0;
            end else begin
                ms_cnt_reg <= ms_cnt_reg + 16'd1;
            end
        end
    end

    // Per-digit source selection and segment encoding.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [4:0] ERR_CODE = (gi < 2)  ? CH_R :
                                              (gi == 2) ? CH_E : CH_BLANK;
            logic [3:0] hex_nib;
            logic [3:0] dec_nib;
            logic       lead_blank;

            if (4*gi + 4 <= VAL_W) begin : g_full
                assign hex_nib = Value[4*gi +: 4];
            end else if (4*gi < VAL_W) begin : g_part
                assign hex_nib = {{(4*gi + 4 - VAL_W){1'b0}}, Value[VAL_W-1:4*gi]};
            end else begin : g_pad
                assign hex_nib = 4'd0;
            end

            if (gi < NSHOW) begin : g_dec
                assign dec_nib = dec_digits_reg[4*gi +: 4];
            end else begin : g_dec_pad
                assign dec_nib = 4'd0;
            end

            assign dec_nz[gi] = |dec_nib;

            if (LZB == 0 || gi == 0) begin : g_no_blank
                assign lead_blank = 1'b0;
            end else if (gi == DIGITS - 1) begin : g_top_blank
                assign lead_blank = ~dec_nz[gi];
            end else begin : g_mid_blank
                assign lead_blank = ~dec_nz[gi] & ~(|dec_nz[DIGITS-1:gi+1]);
            end

            assign char_next[5*gi +: 5] =
                overlay_reg  ? msg_reg[5*gi +: 5] :
                dispMode     ? (hex_err ? ERR_CODE : {1'b0, hex_nib}) :
                overflow_reg ? ERR_CODE :
                lead_blank   ? CH_BLANK : {1'b0, dec_nib};

            hex_driver u_hex (
                .char_code (char_reg[5*gi +: 5]),
                .seg       (HEX[8*gi +: 8])
            );
        end
    endgenerate

    // Display character register: refreshed from the selected source every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_reg <= {DIGITS{CH_BLANK}};
        end else begin
            char_reg <= char_next;
        end
    end

    assign unused_bits = &{1'b0, bcd_adj[4*NBCD-1], dec_nz};

endmodule

// Character code to active-low segments {dp, g, f, e, d, c, b, a}.
module hex_driver (
    input  logic [4:0] char_code,
    output logic [7:0] seg
);

    // Purely combinational glyph lookup; unknown codes show blank.
    always_comb begin
        seg = 8'hFF;
        case (char_code)
            5'h00: seg = 8'hC0;
            5'h01: seg = 8'hF9;
            5'h02: seg = 8'hA4;
            5'h03: seg = 8'hB0;
            5'h04: seg = 8'h99;
            5'h05: seg = 8'h92;
            5'h06: seg = 8'h82;
            5'h07: seg = 8'hF8;
            5'h08: seg = 8'h80;
            5'h09: seg = 8'h90;
            5'h0A: seg = 8'h88;
            5'h0B: seg = 8'h83;
            5'h0C: seg = 8'hC6;
            5'h0D: seg = 8'hA1;
            5'h0E: seg = 8'h86;
            5'h0F: seg = 8'h8E;
            5'h10: seg = 8'hAF;
            5'h11: seg = 8'hA3;
            5'h12: seg = 8'hC2;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed steps plus randomized
// values and overlay tick spacing, checked against an arithmetic model.
module tb_seg_display_ctrl;

    localparam int DIGITS  = 6;
    localparam int VAL_W   = 24;
    localparam int TIMEOUT = 3000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 oneMsPulse;
    logic                 dispMode;
    logic [VAL_W-1:0]     Value;
    logic                 ShowMsg;
    logic [5*DIGITS-1:0]  MsgChars;
    logic                 Busy;
    logic                 OverlayActive;
    logic [8*DIGITS-1:0]  HEX;

    int nchecks = 0;
    int nerrors = 0;
    int since   = 0;
    logic [5*DIGITS-1:0] cur_msg;

    seg_display_ctrl #(
        .DIGITS     (DIGITS),
        .VAL_W      (VAL_W),
        .TIMEOUT_MS (TIMEOUT),
        .LZB        (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .oneMsPulse    (oneMsPulse),
        .dispMode      (dispMode),
        .Value         (Value),
        .ShowMsg       (ShowMsg),
        .MsgChars      (MsgChars),
        .Busy          (Busy),
        .OverlayActive (OverlayActive),
        .HEX           (HEX)
    );

    always #5 clk = ~clk;

    // Glyph table, active-low {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] seg_of(input logic [4:0] c);
        case (c)
            5'h00: return 8'hC0;
            5'h01: return 8'hF9;
            5'h02: return 8'hA4;
            5'h03: return 8'hB0;
            5'h04: return 8'h99;
            5'h05: return 8'h92;
            5'h06: return 8'h82;
            5'h07: return 8'hF8;
            5'h08: return 8'h80;
            5'h09: return 8'h90;
            5'h0A: return 8'h88;
            5'h0B: return 8'h83;
            5'h0C: return 8'hC6;
            5'h0D: return 8'hA1;
            5'h0E: return 8'h86;
            5'h0F: return 8'h8E;
            5'h10: return 8'hAF;
            5'h11: return 8'hA3;
            5'h12: return 8'hC2;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected HEX for a value in hex or decimal view.
    function automatic logic [8*DIGITS-1:0] show_value(input logic hexm, input int unsigned v);
        logic [4:0]          codes [DIGITS];
        logic [8*DIGITS-1:0] r;
        int unsigned         rem;
        int unsigned         limit;
        bit                  seen;
        limit = 1;
        for (int k = 0; k < DIGITS; k++) limit = limit * 10;
        if (hexm) begin
            for (int k = 0; k < DIGITS; k++) codes[k] = 5'((v >> (4*k)) & 15);
        end else if (v >= limit) begin
            for (int k = 0; k < DIGITS; k++) codes[k] = 5'h13;
            codes[2] = 5'h0E;
            codes[1] = 5'h10;
            codes[0] = 5'h10;
        end else begin
            rem = v;
            for (int k = 0; k < DIGITS; k++) begin
                codes[k] = 5'(rem % 10);
                rem = rem / 10;
            end
            seen = 1'b0;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (codes[k] != 0) seen = 1'b1;
                if (!seen) codes[k] = 5'h13;
            end
        end
        for (int k = 0; k < DIGITS; k++) r[8*k +: 8] = seg_of(codes[k]);
        return r;
    endfunction

    function automatic logic [8*DIGITS-1:0] show_msg(input logic [5*DIGITS-1:0] m);
        logic [8*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) r[8*k +: 8] = seg_of(m[5*k +: 5]);
        return r;
    endfunction

    function automatic logic [5*DIGITS-1:0] rand_msg();
        logic [5*DIGITS-1:0] m;
        for (int k = 0; k < DIGITS; k++) m[5*k +: 5] = 5'($urandom_range(0, 19));
        return m;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [8*DIGITS-1:0] obs,
                       input logic [8*DIGITS-1:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One ms tick after a random gap; returns just after the sampling edge.
    task automatic ms_tick();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        oneMsPulse = 1'b1;
        @(negedge clk);
        oneMsPulse = 1'b0;
        since++;
    endtask

    // Ticks that must all keep the overlay up.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick();
            chk("ovl_held", 48'(OverlayActive), 48'(since < TIMEOUT));
            chk("ovl_hex", HEX, show_msg(cur_msg));
        end
    endtask

    task automatic do_show(input logic [5*DIGITS-1:0] m, input logic with_tick);
        MsgChars   = m;
        ShowMsg    = 1'b1;
        oneMsPulse = with_tick;
        step(1);
        ShowMsg    = 1'b0;
        oneMsPulse = 1'b0;
        since      = 0;
        cur_msg    = m;
        chk("ovl_start", 48'(OverlayActive), 48'd1);
        step(1);
        chk("ovl_first_hex", HEX, show_msg(m));
        $display("overlay shown msg=%h tick_coincident=%0d", m, with_tick);
    endtask

    // Last tick of an overlay: flag drops at once, HEX one cycle later.
    task automatic end_overlay(input logic hexm);
        ms_tick();
        chk("ovl_end", 48'(OverlayActive), 48'd0);
        chk("ovl_last_hex", HEX, show_msg(cur_msg));
        step(1);
        chk("ovl_back", HEX, show_value(hexm, Value));
        $display("overlay ended after %0d ticks, value=%0d hex=%0d", since, Value, hexm);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned v, tmp, old_v;
        logic        hexm;
        logic [5*DIGITS-1:0] m;

        rst = 1'b1; oneMsPulse = 1'b0; dispMode = 1'b0; Value = '0;
        ShowMsg = 1'b0; MsgChars = '0; cur_msg = '0;

        // Reset state.
        step(2);
        chk("rst_hex", HEX, {DIGITS{8'hFF}});
        chk("rst_busy", 48'(Busy), 48'd0);
        chk("rst_ovl", 48'(OverlayActive), 48'd0);
        rst = 1'b0;
        step(2);
        chk("zero_after_rst", HEX, show_value(1'b0, 0));
        $display("reset released");

        // Exact decimal latency on 123456.
        Value = 24'd123456;
        step(1);
        chk("busy_rise", 48'(Busy), 48'd1);
        step(VAL_W + 1);
        chk("dec_not_yet", HEX, show_value(1'b0, 0));
        step(1);
        chk("dec_123456", HEX, show_value(1'b0, 123456));
        chk("busy_fall", 48'(Busy), 48'd0);
        $display("converted 123456");

        // Leading-zero blanking and zero.
        Value = 24'd42;
        step(VAL_W + 3);
        chk("dec_42", HEX, show_value(1'b0, 42));
        Value = 24'd0;
        step(VAL_W + 3);
        chk("dec_0", HEX, show_value(1'b0, 0));
        $display("converted 42 and 0");

        // Decimal overflow, then hex view one cycle later.
        Value = 24'd1000000;
        step(VAL_W + 3);
        chk("dec_err", HEX, show_value(1'b0, 1000000));
        dispMode = 1'b1;
        step(1);
        chk("hex_0F4240", HEX, show_value(1'b1, 1000000));
        dispMode = 1'b0;
        step(1);
        chk("back_to_err", HEX, show_value(1'b0, 1000000));
        $display("overflow and hex 0F4240");

        // Abort mid-conversion: no intermediate value may appear.
        Value = 24'd7;
        step(VAL_W + 3);
        chk("dec_7", HEX, show_value(1'b0, 7));
        Value = 24'd100;
        step(10);
        Value = 24'd200;
        for (int i = 0; i < VAL_W + 2; i++) begin
            step(1);
            chk("no_intermediate", HEX, show_value(1'b0, 7));
        end
        step(1);
        chk("dec_200", HEX, show_value(1'b0, 200));
        $display("abort 100 -> 200");

        // Randomized values, some aborted mid-conversion, both views.
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 2) == 0) v = $urandom & 32'hFF_FFFF;
            else                           v = $urandom_range(0, 999999);
            if ($urandom_range(0, 1) == 1) begin
                tmp = $urandom & 32'hFF_FFFF;
                Value = VAL_W'(tmp);
                step($urandom_range(1, 20));
            end
            Value = VAL_W'(v);
            step(VAL_W + 3);
            chk("rand_dec", HEX, show_value(1'b0, v));
            dispMode = 1'b1;
            step(1);
            chk("rand_hex", HEX, show_value(1'b1, v));
            dispMode = 1'b0;
            $display("random value=%0d", v);
        end

        // Overlay extended by a second ShowMsg at tick 2000; value changes underneath.
        Value = VAL_W'($urandom_range(0, 999999));
        step(VAL_W + 3);
        m = {5'h10, 5'h0E, 5'h12, 5'h13, 5'h0A, 5'h05};
        do_show(m, 1'b0);
        run_ticks(2000);
        old_v = $urandom_range(0, 999999);
        Value = VAL_W'(old_v);
        do_show(rand_msg(), 1'b0);
        run_ticks(TIMEOUT - 1);
        end_overlay(1'b0);

        // ShowMsg coinciding with the timeout tick keeps the overlay; hex view after.
        dispMode = 1'b1;
        Value = VAL_W'($urandom & 32'hFF_FFFF);
        do_show(rand_msg(), 1'b0);
        run_ticks(TIMEOUT - 1);
        do_show(rand_msg(), 1'b1);
        run_ticks(TIMEOUT - 1);
        end_overlay(1'b1);
        dispMode = 1'b0;

        // Reset in the middle of an overlay and a conversion.
        do_show(rand_msg(), 1'b0);
        run_ticks(5);
        v = $urandom_range(1, 999999);
        Value = VAL_W'(v);
        step(5);
        chk("busy_mid", 48'(Busy), 48'd1);
        rst = 1'b1;
        #1;
        chk("midrst_hex", HEX, {DIGITS{8'hFF}});
        chk("midrst_busy", 48'(Busy), 48'd0);
        chk("midrst_ovl", 48'(OverlayActive), 48'd0);
        step(3);
        rst = 1'b0;
        step(VAL_W + 4);
        chk("reconv", HEX, show_value(1'b0, v));
        chk("reconv_ovl", 48'(OverlayActive), 48'd0);
        $display("reset mid-activity, reconverted %0d", v);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
